multiport_state_ram: RTL and testbench

Parametrised lookahead state memory: one write port and NUM_RD_PORTS independent read ports, each read port with a registered one-cycle read latency and write-first bypass. Optional zero-sweep on reset, plus a run-time `clear` request that re-sweeps the whole array. Used by streaming adapters and multi-channel datapath blocks to hold per-channel state such as byte phase or partial words, where the state is read and rewritten every cycle.

---
 rtl/multiport_state_ram.sv | 120 ++++++++++++
 tb/tb_multiport_state_ram.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_state_ram.sv
// Per-channel state memory: one write port, NUM_RD_PORTS registered read ports with
// write-first bypass, plus a zero-sweep on reset and on a run-time clear request.
module multiport_state_ram #(
    parameter int DEPTH          = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int NUM_RD_PORTS   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [ADDRESS_WIDTH-1:0]              wr_address,
    input  logic [DATA_WIDTH-1:0]                 wr_writedata,
    input  logic                                  wr_write,
    output logic                                  wr_waitrequest,
    input  logic                                  clear,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_address,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_readdata
);

    localparam logic StSweep = 1'b0;
    localparam logic StRun   = 1'b1;

    localparam logic                     ResetState = (CLEAR_ON_RESET != 0) ? StSweep : StRun;
    localparam logic [ADDRESS_WIDTH-1:0] LastAddr   = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   DepthW     = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] count_q, count_d;
    logic                     wait_q, wait_d;
    logic [DATA_WIDTH-1:0]    wdata_q;

    logic                     sweeping;
    logic                     wr_accept;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    logic [DATA_WIDTH-1:0]    port_data [NUM_RD_PORTS];

    assign sweeping = (state_q == StSweep);

    // clear beats a same-cycle write; writes are only taken in RUN with waitrequest low
    assign wr_accept = wr_write && !wait_q && !clear && (state_q == StRun) &&
                       ({1'b0, wr_address} < DepthW);

    assign mem_we    = sweeping || wr_accept;
    assign mem_waddr = sweeping ? count_q : wr_address;
    assign mem_wdata = sweeping ? '0 : wr_writedata;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = StSweep;
            count_d = LastAddr;
        end else if (state_q == StSweep) begin
            if (count_q == '0) begin
                state_d = StRun;
            end else begin
                count_d = count_q - ADDRESS_WIDTH'(1);
            end
        end
        wait_d = (state_d == StSweep);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ResetState;
            count_q <= LastAddr;
            wait_q  <= 1'b1;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            wdata_q <= wr_writedata;
        end
    end

    assign wr_waitrequest = wait_q;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gen_port
        logic [DATA_WIDTH-1:0]    mem [DEPTH];
        logic [ADDRESS_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0]    ram_q;
        logic                     hit_q;
        logic                     zero_q;

        assign ra = rd_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // Plain RAM replica: read-before-write, the bypass covers same-address writes
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
            ram_q <= mem[ra];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hit_q  <= 1'b0;
                zero_q <= 1'b1;
            end else begin
                hit_q  <= wr_accept && (wr_address == ra);
                zero_q <= sweeping || !({1'b0, ra} < DepthW);
            end
        end

        assign port_data[p] = zero_q ? '0 : (hit_q ? wdata_q : ram_q);
    end

    always_comb begin
        rd_readdata = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_readdata[p*DATA_WIDTH +: DATA_WIDTH] = port_data[p];
        end
    end

endmodule

// File: tb/tb_multiport_state_ram.sv
// Scoreboard bench: stimulus pushes expected values tagged with the edge they are due on,
// a monitor pops and compares them just after each rising edge.
module tb_multiport_state_ram;

    typedef struct {
        int unsigned due;
        int          kind;
        int          port;
        logic [7:0]  exp;
    } exp_t;

    logic        clk;
    logic        rst0_n, rst1_n;

    logic [3:0]  wr_address0, wr_address1;
    logic [7:0]  wr_writedata0, wr_writedata1;
    logic        wr_write0, wr_write1;
    logic        wait0, wait1;
    logic        clear0, clear1;
    logic [7:0]  rd_address0;
    logic [15:0] rd_readdata0;
    logic [15:0] rd_address1;
    logic [31:0] rd_readdata1;

    exp_t        sb [$];
    exp_t        mon_e;
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  model [12];
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        we;
    logic [3:0]  ra [4];
    logic [7:0]  ev;

    multiport_state_ram #(
        .DEPTH(16), .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1)
    ) u0 (
        .clk(clk), .reset_n(rst0_n),
        .wr_address(wr_address0), .wr_writedata(wr_writedata0), .wr_write(wr_write0),
        .wr_waitrequest(wait0), .clear(clear0),
        .rd_address(rd_address0), .rd_readdata(rd_readdata0)
    );

    multiport_state_ram #(
        .DEPTH(12), .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .NUM_RD_PORTS(4), .CLEAR_ON_RESET(1)
    ) u1 (
        .clk(clk), .reset_n(rst1_n),
        .wr_address(wr_address1), .wr_writedata(wr_writedata1), .wr_write(wr_write1),
        .wr_waitrequest(wait1), .clear(clear1),
        .rd_address(rd_address1), .rd_readdata(rd_readdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        logic [7:0] act;
        string      nm;
        edge_cnt++;
        #1;
        while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                0:       begin act = rd_readdata0[mon_e.port*8 +: 8];
                               nm = $sformatf("u0_rd%0d", mon_e.port); end
                1:       begin act = rd_readdata1[mon_e.port*8 +: 8];
                               nm = $sformatf("u1_rd%0d", mon_e.port); end
                2:       begin act = {7'd0, wait0}; nm = "u0_wait"; end
                default: begin act = {7'd0, wait1}; nm = "u1_wait"; end
            endcase
            n_checks++;
            if (act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s edge %0d: got %h expected %h", nm, mon_e.due, act, mon_e.exp);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [7:0] v);
        exp_t e;
        e.due  = edge_cnt + 1;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Sweep of n edges starting at the next edge; optional ignored write to addr 9 at edge wr_at.
    task automatic sweep_check(input int inst, input int n, input int wr_at);
        for (int i = 1; i <= n; i++) begin
            if (inst == 0) begin
                wr_write0     = (i == wr_at);
                wr_address0   = 4'd9;
                wr_writedata0 = 8'hEE;
                rd_address0   = 8'($urandom);
                push(0, 0, 8'h00);
                push(0, 1, 8'h00);
                push(2, 0, {7'd0, (i < n)});
            end else begin
                rd_address1 = 16'($urandom);
                for (int p = 0; p < 4; p++) push(1, p, 8'h00);
                push(3, 0, {7'd0, (i < n)});
            end
            tick();
        end
        wr_write0 = 1'b0;
    endtask

    task automatic read_all_zero0();
        for (int a = 0; a < 16; a++) begin
            rd_address0 = {4'(15 - a), 4'(a)};
            push(0, 0, 8'h00);
            push(0, 1, 8'h00);
            tick();
        end
    endtask

    task automatic fill0(input int offset);
        for (int a = 0; a < 16; a++) begin
            wr_write0     = 1'b1;
            wr_address0   = 4'(a);
            wr_writedata0 = 8'(a + offset);
            rd_address0   = {4'(a), 4'(a)};
            push(0, 0, 8'(a + offset));
            push(0, 1, 8'(a + offset));
            tick();
        end
        wr_write0 = 1'b0;
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        wr_address0 = '0; wr_writedata0 = '0; wr_write0 = 1'b0; clear0 = 1'b0; rd_address0 = '0;
        wr_address1 = '0; wr_writedata1 = '0; wr_write1 = 1'b0; clear1 = 1'b0; rd_address1 = '0;
        tick();

        // reset state
        for (int c = 0; c < 2; c++) begin
            push(0, 0, 8'h00); push(0, 1, 8'h00); push(2, 0, 8'h01);
            for (int p = 0; p < 4; p++) push(1, p, 8'h00);
            push(3, 0, 8'h01);
            tick();
        end

        rst0_n = 1'b1;
        sweep_check(0, 16, 0);

        // preload 0xFF, then reset while outputs are nonzero and check the re-sweep
        for (int a = 0; a < 16; a++) begin
            wr_write0     = 1'b1;
            wr_address0   = 4'(a);
            wr_writedata0 = 8'hFF;
            rd_address0   = {4'd15, 4'(a)};
            push(0, 0, 8'hFF);
            push(0, 1, (a == 15) ? 8'hFF : 8'h00);
            push(2, 0, 8'h00);
            tick();
        end
        wr_write0   = 1'b0;
        rd_address0 = {4'd5, 4'd0};
        push(0, 0, 8'hFF); push(0, 1, 8'hFF);
        tick();
        rst0_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            push(0, 0, 8'h00); push(0, 1, 8'h00); push(2, 0, 8'h01);
            tick();
        end
        rst0_n = 1'b1;
        sweep_check(0, 16, 0);
        read_all_zero0();

        // same-cycle bypass
        wr_write0 = 1'b1; wr_address0 = 4'd4; wr_writedata0 = 8'h44;
        tick();
        wr_address0 = 4'd3; wr_writedata0 = 8'hA5; rd_address0 = {4'd4, 4'd3};
        push(0, 0, 8'hA5); push(0, 1, 8'h44);
        tick();
        wr_write0 = 1'b0; rd_address0 = {4'd3, 4'd3};
        push(0, 0, 8'hA5); push(0, 1, 8'hA5);
        tick();

        // run-time clear with a colliding write
        fill0(1);
        clear0 = 1'b1; wr_write0 = 1'b1; wr_address0 = 4'd2; wr_writedata0 = 8'h77;
        rd_address0 = {4'd5, 4'd2};
        push(0, 0, 8'h03); push(0, 1, 8'h06); push(2, 0, 8'h01);
        tick();
        clear0 = 1'b0; wr_write0 = 1'b0;
        sweep_check(0, 16, 0);
        rd_address0 = {4'd2, 4'd2};
        push(0, 0, 8'h00); push(0, 1, 8'h00);
        tick();
        read_all_zero0();

        // clear restart: 21 edges of waitrequest, write during sweep dropped
        clear0 = 1'b1; push(2, 0, 8'h01); tick();
        clear0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            push(2, 0, 8'h01);
            tick();
        end
        clear0 = 1'b1; push(2, 0, 8'h01); tick();
        clear0 = 1'b0;
        sweep_check(0, 16, 12);
        wr_write0 = 1'b1; wr_address0 = 4'd7; wr_writedata0 = 8'h5A; rd_address0 = {4'd9, 4'd7};
        push(0, 0, 8'h5A); push(0, 1, 8'h00); push(2, 0, 8'h00);
        tick();
        wr_write0 = 1'b0;

        // reset mid-sweep
        fill0(16);
        clear0 = 1'b1; push(2, 0, 8'h01); tick();
        clear0 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rd_address0 = {4'd1, 4'd0};
            push(0, 0, 8'h00); push(0, 1, 8'h00); push(2, 0, 8'h01);
            tick();
        end
        rst0_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            push(0, 0, 8'h00); push(0, 1, 8'h00); push(2, 0, 8'h01);
            tick();
        end
        rst0_n = 1'b1;
        sweep_check(0, 16, 0);
        read_all_zero0();

        // random model check on the 12-deep, 4-port instance
        rst1_n = 1'b1;
        sweep_check(1, 12, 0);
        for (int i = 0; i < 12; i++) model[i] = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            for (int p = 0; p < 4; p++) begin
                ra[p] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            end
            wr_write1 = we; wr_address1 = wa; wr_writedata1 = wd;
            rd_address1 = {ra[3], ra[2], ra[1], ra[0]};
            for (int p = 0; p < 4; p++) begin
                if (we && wa < 4'd12 && ra[p] == wa) ev = wd;
                else if (ra[p] < 4'd12)              ev = model[ra[p]];
                else                                 ev = 8'h00;
                push(1, p, ev);
            end
            push(3, 0, 8'h00);
            if (we && wa < 4'd12) model[wa] = wd;
            tick();
        end
        wr_write1 = 1'b0;

        tick();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
